// File: rtl/sample_capture_if.sv
// Bus bundle for sample_capture: the upstream sample stream (valid/ready
// handshake) and the random-access readback port (addr in, registered data out).
//   master : stream producer / readback host (drives in_valid, in_data, addr)
//   slave  : capture buffer (drives in_ready, data)
interface sample_capture_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (
    output in_valid, in_data, addr,
    input  in_ready, data
  );

  modport slave (
    input  in_valid, in_data, addr,
    output in_ready, data
  );
endinterface

// File: rtl/sample_capture.sv
// sample_capture: stores a 2^ADDR_W-sample record of the filtered stream in
// on-chip RAM, tracks the record's peak magnitude, and serves readback through
// a 1-cycle registered random-access port.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   start          : pulse, arms a new capture (ignored while capturing)
//   clear          : pulse, returns to idle; wins over start and over an accept
//   s_if           : in_valid/in_data/in_ready stream, addr/data readback
//   busy, done     : capture in progress / record complete
//   count          : samples stored, 0..2^ADDR_W
//   peak           : largest |sample| in the current record (unsigned)
module sample_capture #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  sample_capture_if.slave   s_if,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] peak
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] peak_q,  peak_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mag;
  logic              wr_en;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // |x| with the most negative value saturated to the largest positive value.
  always_comb begin
    mag = s_if.in_data;
    if (s_if.in_data[DATA_W-1]) begin
      mag = (s_if.in_data == MIN_NEG) ? MAX_POS : -s_if.in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    peak_d  = peak_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      peak_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_CAPTURE;
            count_d = '0;
            peak_d  = '0;
          end
        end
        ST_CAPTURE: begin
          if (s_if.in_valid) begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_ONE;
            if (mag > peak_q) peak_d = mag;
            // In CAPTURE count never exceeds 2^ADDR_W-1, so all-ones in the
            // low bits means this accept completes the record.
            if (count_q[ADDR_W-1:0] == '1) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  // RAM has no reset so its contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[count_q[ADDR_W-1:0]] <= s_if.in_data;
  end

  // Read register samples the pre-write contents (read-before-write).
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= mem[s_if.addr];
  end

  always_comb begin
    busy          = (state_q == ST_CAPTURE);
    done          = (state_q == ST_DONE);
    s_if.in_ready = busy;
    s_if.data     = data_q;
    count         = count_q;
    peak          = peak_q;
  end

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture with a behavioural record model.
module tb_sample_capture;

  logic        clk = 1'b0;
  logic        reset, start, clear;
  logic        busy, done;
  logic [10:0] count;
  logic [15:0] peak;

  sample_capture_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  sample_capture #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .clear (clear),
    .s_if  (bus),
    .busy  (busy),
    .done  (done),
    .count (count),
    .peak  (peak)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the record: flags, sample count, running peak, RAM.
  bit          m_busy, m_done;
  int          m_count, m_peak;
  logic [15:0] m_data;
  logic [15:0] m_mem [1024];

  function automatic int mag16(input logic [15:0] d);
    int x;
    x = int'($signed(d));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return x;
  endfunction

  function automatic logic [29:0] act_status();
    return {bus.in_ready, busy, done, count, peak};
  endfunction

  function automatic logic [29:0] exp_status();
    return {m_busy, m_busy, m_done, 11'(m_count), 16'(m_peak)};
  endfunction

  // Drive one cycle of inputs, advance one edge, apply the record rules to the
  // model, and return 1 ns after the edge for sampling.
  task automatic step(input bit st, input bit cl, input bit rs, input bit v,
                      input logic [15:0] d, input logic [9:0] a);
    int mg;
    start = st; clear = cl; reset = rs;
    bus.in_valid = v; bus.in_data = d; bus.addr = a;
    @(posedge clk);
    m_data = rs ? 16'h0000 : m_mem[a];
    if (rs || cl) begin
      m_busy = 0; m_done = 0; m_count = 0; m_peak = 0;
    end else if (m_busy) begin
      if (v) begin
        m_mem[m_count] = d;
        m_count++;
        mg = mag16(d);
        if (mg > m_peak) m_peak = mg;
        if (m_count == 1024) begin m_busy = 0; m_done = 1; end
      end
    end else if (st) begin
      m_busy = 1; m_done = 0; m_count = 0; m_peak = 0;
    end
    #1;
  endtask

  task automatic idle_read(input logic [9:0] a);
    step(0, 0, 0, 0, 16'($urandom), a);
  endtask

  task automatic test_reset();
    step(0, 0, 1, 1, 16'($urandom), 10'($urandom));
    step(1, 0, 1, 1, 16'($urandom), 10'($urandom));
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (peak !== 16'h0) begin n_bad++; $display("FAIL reset_peak: got %h expected 0000", peak); end
    n_cmp++; if (bus.data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", bus.data); end
    step(0, 0, 0, 1, 16'($urandom), 10'($urandom));
    n_cmp++; if (act_status() !== exp_status()) begin n_bad++; $display("FAIL idle_no_accept: got %h expected %h", act_status(), exp_status()); end
  endtask

  // Ramp capture, full sweep readback, start ignored mid-capture, re-arm from DONE.
  task automatic test_ramp();
    step(1, 0, 0, 0, 16'h0, 10'h0);
    n_cmp++; if (act_status() !== exp_status()) begin n_bad++; $display("FAIL ramp_armed: got %h expected %h", act_status(), exp_status()); end
    for (int i = 0; i < 1024; i++) begin
      step(i == 100, 0, 0, 1, 16'(i), 10'($urandom));
      if (i == 511 || i == 1022) begin
        n_cmp++; if (act_status() !== exp_status()) begin n_bad++; $display("FAIL ramp_mid_%0d: got %h expected %h", i, act_status(), exp_status()); end
      end
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ramp_done: got done=%b busy=%b rdy=%b expected 1 0 0", done, busy, bus.in_ready); end
    n_cmp++; if (count !== 11'd1024) begin n_bad++; $display("FAIL ramp_count: got %0d expected 1024", count); end
    n_cmp++; if (peak !== 16'h03FF) begin n_bad++; $display("FAIL ramp_peak: got %h expected 03ff", peak); end
    for (int a = 0; a < 1024; a++) begin
      idle_read(10'(a));
      n_cmp++; if (bus.data !== 16'(a)) begin n_bad++; $display("FAIL ramp_read[%0d]: got %h expected %h", a, bus.data, 16'(a)); end
    end
    step(1, 0, 0, 0, 16'h0, 10'h0);
    n_cmp++; if (act_status() !== exp_status()) begin n_bad++; $display("FAIL rearm_from_done: got %h expected %h", act_status(), exp_status()); end
  endtask

  // in_valid toggling: 1024 writes over 2048 cycles, then DONE ignores samples.
  task automatic test_toggle();
    step(0, 1, 0, 0, 16'h0, 10'h0);
    step(1, 0, 0, 0, 16'h0, 10'h0);
    for (int c = 0; c < 2048; c++) begin
      step(0, 0, 0, (c % 2) == 1, 16'($urandom), 10'($urandom));
      n_cmp++; if (act_status() !== exp_status()) begin n_bad++; $display("FAIL toggle_cyc%0d: got %h expected %h", c, act_status(), exp_status()); end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL toggle_done_at_2048: got %b expected 1", done); end
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 16'($urandom), 10'($urandom));
    n_cmp++; if (count !== 11'd1024 || done !== 1'b1) begin n_bad++; $display("FAIL done_extra: got count=%0d done=%b expected 1024 1", count, done); end
    for (int a = 0; a < 1024; a++) begin
      idle_read(10'(a));
      n_cmp++; if (bus.data !== m_data) begin n_bad++; $display("FAIL toggle_read[%0d]: got %h expected %h", a, bus.data, m_data); end
    end
  endtask

  task automatic test_peak();
    logic [15:0] fixed1 [3];
    logic [15:0] fixed2 [2];
    logic [15:0] d;
    fixed1 = '{16'h8000, 16'hFFFF, 16'h1234};
    fixed2 = '{16'hFFFE, 16'h0003};
    step(0, 1, 0, 0, 16'h0, 10'h0);
    step(1, 0, 0, 0, 16'h0, 10'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, fixed1[i], 10'h0);
      n_cmp++; if (peak !== 16'h7FFF) begin n_bad++; $display("FAIL peak_sat_%0d: got %h expected 7fff", i, peak); end
    end
    step(0, 1, 0, 0, 16'h0, 10'h0);
    step(1, 0, 0, 0, 16'h0, 10'h0);
    step(0, 0, 0, 1, fixed2[0], 10'h0);
    n_cmp++; if (peak !== 16'h0002) begin n_bad++; $display("FAIL peak_neg2: got %h expected 0002", peak); end
    step(0, 0, 0, 1, fixed2[1], 10'h0);
    n_cmp++; if (peak !== 16'h0003) begin n_bad++; $display("FAIL peak_pos3: got %h expected 0003", peak); end
    for (int i = 0; i < 300; i++) begin
      d = 16'($urandom) >> $urandom_range(2, 15);
      if ($urandom_range(0, 1) == 1) d = ~d;
      step(0, 0, 0, $urandom_range(0, 3) != 0, d, 10'($urandom));
      n_cmp++; if (peak !== 16'(m_peak)) begin n_bad++; $display("FAIL peak_rand%0d: got %h expected %h", i, peak, 16'(m_peak)); end
    end
  endtask

  // clear with a simultaneous sample after 500 accepts; restart writes from 0.
  task automatic test_clear();
    logic [15:0] old500;
    step(0, 1, 0, 0, 16'h0, 10'h0);
    step(1, 0, 0, 0, 16'h0, 10'h0);
    for (int i = 0; i < 500; i++) step(0, 0, 0, 1, 16'($urandom), 10'($urandom));
    old500 = m_mem[500];
    step(1, 1, 0, 1, ~old500, 10'd500);
    n_cmp++; if (act_status() !== 30'h0) begin n_bad++; $display("FAIL clear_status: got %h expected 00000000", act_status()); end
    idle_read(10'd500);
    n_cmp++; if (bus.data !== old500) begin n_bad++; $display("FAIL clear_no_write: got %h expected %h", bus.data, old500); end
    step(1, 0, 0, 0, 16'h0, 10'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 16'($urandom), 10'($urandom));
    n_cmp++; if (count !== 11'd5 || busy !== 1'b1) begin n_bad++; $display("FAIL restart_count: got count=%0d busy=%b expected 5 1", count, busy); end
    for (int a = 0; a < 6; a++) begin
      idle_read(10'(a));
      n_cmp++; if (bus.data !== m_data) begin n_bad++; $display("FAIL restart_read[%0d]: got %h expected %h", a, bus.data, m_data); end
    end
  endtask

  // Reset at count=300 with a sample offered; captured data survives.
  task automatic test_reset_mid();
    logic [15:0] cap[$];
    logic [15:0] d;
    step(0, 1, 0, 0, 16'h0, 10'h0);
    step(1, 0, 0, 0, 16'h0, 10'h0);
    for (int i = 0; i < 300; i++) begin
      d = 16'($urandom);
      cap.push_back(d);
      step(0, 0, 0, 1, d, 10'($urandom));
    end
    n_cmp++; if (count !== 11'd300) begin n_bad++; $display("FAIL pre_reset_count: got %0d expected 300", count); end
    step(1, 0, 1, 1, 16'($urandom), 10'd5);
    n_cmp++; if (act_status() !== 30'h0 || bus.data !== 16'h0) begin n_bad++; $display("FAIL midreset_outputs: got %h/%h expected 00000000/0000", act_status(), bus.data); end
    for (int a = 0; a < 300; a++) begin
      idle_read(10'(a));
      n_cmp++; if (bus.data !== cap[a]) begin n_bad++; $display("FAIL midreset_read[%0d]: got %h expected %h", a, bus.data, cap[a]); end
    end
    idle_read(10'd300);
    n_cmp++; if (bus.data !== m_data) begin n_bad++; $display("FAIL midreset_read[300]: got %h expected %h", bus.data, m_data); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 'x;
    m_busy = 0; m_done = 0; m_count = 0; m_peak = 0; m_data = '0;
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.addr = '0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_toggle();
    test_peak();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Capture buffer that receives the 16-bit processed sample stream from the filter pipeline and stores a fixed-length record of 1024 samples in on-chip RAM. Once the record is complete, the bench or host reads it back through a random-access port using the same addr/data convention as the `Sample` source ROM. It also tracks the record's peak magnitude. The block sits at the output end of the filtering pipeline.

## Interface
- DATA_W, 16, sample width; samples are signed two's complement
- ADDR_W, 10, address width; record depth is 2^ADDR_W = 1024
- clk  in  1  single system clock; all logic runs on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that arms a new capture
- clear  in  1  one-cycle pulse that returns the block to idle
- in_valid  in  1  an input sample is present
- in_data  in  DATA_W  input sample
- in_ready  out  1  block accepts a sample this cycle
- addr  in  ADDR_W  read address
- data  out  DATA_W  registered read data
- busy  out  1  a capture is in progress
- done  out  1  the record is complete
- count  out  ADDR_W+1  number of samples stored, 0..1024
- peak  out  DATA_W  largest |sample| in the current record, unsigned

## Operation
- States: IDLE, CAPTURE, DONE. Encoding is free; state is registered.
- IDLE: start goes to CAPTURE. On that edge, count and peak are cleared to 0.
- CAPTURE:
  - in_ready = 1.
  - Each accept (in_valid & in_ready) writes in_data to RAM[count[ADDR_W-1:0]], then count increments.
  - When the accept makes count reach 1024, go to DONE.
- DONE: start re-arms the block exactly as from IDLE.
- start while in CAPTURE is ignored.
- clear from any state goes to IDLE and sets count=0, peak=0, done=0.
  - clear has priority over start and over a simultaneous accept; that sample is not written.
- RAM contents survive reset and clear. Stale locations keep old data until overwritten.
- Peak:
  - |x| = x when x ≥ 0, else -x.
  - -32768 (0x8000) saturates to 32767 (0x7FFF).
  - On each accept, peak = max(peak, |x|).
- Read port:
  - data updates every cycle from RAM[addr] in every state.
  - If addr equals the write address in the same cycle, data returns the old contents (read-before-write).
- Outputs: busy = (state==CAPTURE); done = (state==DONE); in_ready = busy.
- Samples presented outside CAPTURE are not accepted. No overflow is possible; upstream must hold or drop them.
- Reset values: state IDLE; in_ready=0, busy=0, done=0, count=0, peak=0, data=0.

## Timing
- start sampled at edge N → busy=1 and in_ready=1 from N+1.
- Accept at edge N → RAM and count updated at N, visible after N.
- Readback of that location: apply addr at edge ≥ N+1; data is valid after the following edge.
- Last (1024th) accept at edge N → count=1024, done=1, busy=0, in_ready=0 after N. No further write occurs.
- Read latency: addr at edge N → data valid after edge N; exactly 1 cycle.
- Throughput: one sample per clock when in_valid is held high. Gaps in in_valid stall the capture without error.
- Reset mid-capture: after the reset edge the block is in IDLE with all outputs at reset values. Partial data remains in RAM.

## Test plan
- Reset → in_ready=0, busy=0, done=0, count=0, peak=0, data=0.
- start, then 1024 continuous samples 0x0000..0x03FF → done after the 1024th accept; count=1024; peak=0x03FF.
  - Then sweep addr 0..1023 → data equals addr, one cycle after each address.
- start, then samples with in_valid toggling every other cycle → exactly 1024 writes in order, total 2048 cycles.
  - Extra samples offered in DONE are not stored; count stays 1024.
- Samples 0x8000, 0xFFFF, 0x1234 → peak=0x7FFF after the first, unchanged thereafter.
  - Repeat with 0xFFFE, 0x0003 → peak=0x0003.
- clear asserted with in_valid high after 500 samples → IDLE, count=0, done=0, and the 501st sample is not written.
  - Then start again → capture proceeds from address 0.
- reset pulsed during capture at count=300 → all outputs return to reset values.
  - RAM[0..299] is still readable with the captured data after the next start/clear-free readback.
